cv32e40p_snn_lif_array: RTL and testbench

Stateful, parametrised leaky-integrate-and-fire neuron array for the SNN extension of the cv32e40p core. It holds an NUM_ROWS x NUM_COLS grid of signed membrane potentials and processes one timestep per start pulse. Each timestep visits rows in order: leak, integrate the incoming current row, fire on threshold, reset potential, track refractory time. Input current rows arrive from the convolution datapath over a valid/ready stream, and spike rows leave over a second stream.

---
 rtl/cv32e40p_snn_lif_array.sv | 140 ++++++++++++++
 tb/tb_cv32e40p_snn_lif_array.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_snn_lif_array.sv
// cv32e40p_snn_lif_array: leaky-integrate-and-fire neuron grid, one row per timestep
// step, current rows in and spike rows out over valid/ready streams.
module cv32e40p_snn_lif_array #(
    parameter int NUM_ROWS = 8,
    parameter int NUM_COLS = 16,
    parameter int DATA_W   = 16,
    parameter int SHIFT_W  = 2,
    parameter int REFR_W   = 3,
    localparam int ROW_W   = $clog2(NUM_ROWS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       clear_i,
    input  logic [SHIFT_W-1:0]         shift_i,
    input  logic                       leak_mode_i,
    input  logic                       reset_mode_i,
    input  logic [DATA_W-1:0]          thresh_i,
    input  logic [REFR_W-1:0]          refr_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [NUM_COLS*DATA_W-1:0] in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_COLS-1:0]        out_spike_o,
    output logic [ROW_W-1:0]           out_row_o,
    output logic                       busy_o,
    output logic                       done_o
);
    typedef enum logic [1:0] {S_IDLE, S_IN, S_OUT, S_DONE} state_t;

    state_t                    r_state, w_next;
    logic [ROW_W-1:0]          r_row;
    logic [NUM_COLS-1:0]       r_spike;
    logic [SHIFT_W-1:0]        r_shift;
    logic                      r_leak_mode, r_reset_mode;
    logic signed [DATA_W-1:0]  r_thresh;
    logic [REFR_W-1:0]         r_refr;
    logic signed [DATA_W-1:0]  r_mem  [NUM_ROWS][NUM_COLS];
    logic [REFR_W-1:0]         r_refc [NUM_ROWS][NUM_COLS];

    logic                      w_last, w_clear, w_start, w_in_hs, w_out_hs;
    logic [NUM_COLS-1:0]       w_spk;
    logic signed [DATA_W-1:0]  w_nv [NUM_COLS];
    logic [REFR_W-1:0]         w_nr [NUM_COLS];

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] a);
        return (a[DATA_W] != a[DATA_W-1]) ? {a[DATA_W], {(DATA_W-1){~a[DATA_W]}}} : a[DATA_W-1:0];
    endfunction

    assign w_last   = r_row == ROW_W'(NUM_ROWS - 1);
    assign w_clear  = (r_state == S_IDLE) && clear_i;
    assign w_start  = (r_state == S_IDLE) && start_i && !clear_i;
    assign w_in_hs  = (r_state == S_IN) && in_valid_i;
    assign w_out_hs = (r_state == S_OUT) && out_ready_i;

    assign in_ready_o  = r_state == S_IN;
    assign out_valid_o = r_state == S_OUT;
    assign done_o      = r_state == S_DONE;
    assign busy_o      = r_state != S_IDLE;
    assign out_spike_o = r_spike;
    assign out_row_o   = r_row;

    // Only the row currently addressed is evaluated; the whole row updates in parallel.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        logic signed [DATA_W-1:0] w_v, w_x, w_sh, w_l, w_u, w_d;
        logic signed [DATA_W:0]   w_sum, w_diff;
        logic [REFR_W-1:0]        w_r;
        assign w_v    = r_mem[r_row][c];
        assign w_r    = r_refc[r_row][c];
        assign w_x    = in_data_i[c*DATA_W +: DATA_W];
        assign w_sh   = w_v >>> r_shift;
        assign w_l    = r_leak_mode ? w_v - w_sh : w_sh;
        assign w_sum  = {w_l[DATA_W-1], w_l} + {w_x[DATA_W-1], w_x};
        assign w_u    = sat(w_sum);
        assign w_diff = {w_u[DATA_W-1], w_u} - {r_thresh[DATA_W-1], r_thresh};
        assign w_d    = sat(w_diff);
        assign w_spk[c] = (w_r == '0) && (w_u >= r_thresh);
        assign w_nv[c]  = (w_r != '0) ? w_v : (w_spk[c] ? (r_reset_mode ? w_d : '0) : w_u);
        assign w_nr[c]  = (w_r != '0) ? w_r - 1'b1 : (w_spk[c] ? r_refr : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_IN : S_IDLE;
            S_IN:    w_next = in_valid_i ? S_OUT : S_IN;
            S_OUT:   w_next = !out_ready_i ? S_OUT : (w_last ? S_DONE : S_IN);
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row        <= '0;
            r_spike      <= '0;
            r_shift      <= '0;
            r_leak_mode  <= 1'b0;
            r_reset_mode <= 1'b0;
            r_thresh     <= '0;
            r_refr       <= '0;
            for (int i = 0; i < NUM_ROWS; i++)
                for (int j = 0; j < NUM_COLS; j++) begin
                    r_mem[i][j]  <= '0;
                    r_refc[i][j] <= '0;
                end
        end else begin
            if (w_clear)
                for (int i = 0; i < NUM_ROWS; i++)
                    for (int j = 0; j < NUM_COLS; j++) begin
                        r_mem[i][j]  <= '0;
                        r_refc[i][j] <= '0;
                    end
            if (w_start) begin
                r_shift      <= shift_i;
                r_leak_mode  <= leak_mode_i;
                r_reset_mode <= reset_mode_i;
                r_thresh     <= thresh_i;
                r_refr       <= refr_i;
                r_row        <= '0;
            end
            if (w_in_hs) begin
                r_spike <= w_spk;
                for (int j = 0; j < NUM_COLS; j++) begin
                    r_mem[r_row][j]  <= w_nv[j];
                    r_refc[r_row][j] <= w_nr[j];
                end
            end
            if (w_out_hs && !w_last)
                r_row <= r_row + 1'b1;
        end
    end
endmodule

// File: tb/tb_cv32e40p_snn_lif_array.sv
// tb_cv32e40p_snn_lif_array: directed timesteps with a row scoreboard checked by an
// independent monitor on the spike stream.
module tb_cv32e40p_snn_lif_array;
    localparam int NR = 8, NC = 16, DW = 16;

    logic clk = 0, rst = 1, start_i = 0, clear_i = 0;
    logic [1:0] shift_i = '0;
    logic leak_mode_i = 0, reset_mode_i = 0;
    logic [DW-1:0] thresh_i = '0;
    logic [2:0] refr_i = '0;
    logic in_valid_i = 0, in_ready_o;
    logic [NC*DW-1:0] in_data_i = '0;
    logic out_valid_o, out_ready_i = 0;
    logic [NC-1:0] out_spike_o;
    logic [2:0] out_row_o;
    logic busy_o, done_o;

    int checks = 0, errors = 0, n_done = 0;
    logic [NC+2:0] sb [$];

    cv32e40p_snn_lif_array dut (
        .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i), .shift_i(shift_i),
        .leak_mode_i(leak_mode_i), .reset_mode_i(reset_mode_i), .thresh_i(thresh_i),
        .refr_i(refr_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_spike_o(out_spike_o), .out_row_o(out_row_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_mem(input string nm, input int exp);
        chk({nm, "[0][0]"}, int'($signed(dut.r_mem[0][0])), exp);
        chk({nm, "[3][7]"}, int'($signed(dut.r_mem[3][7])), exp);
        chk({nm, "[7][15]"}, int'($signed(dut.r_mem[NR-1][NC-1])), exp);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_in_ready"}, in_ready_o, 0);
        chk({nm, "_out_valid"}, out_valid_o, 0);
        chk({nm, "_spike"}, out_spike_o, 0);
        chk({nm, "_row"}, out_row_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_done"}, done_o, 0);
    endtask

    always @(negedge clk) begin
        logic [NC+2:0] e;
        if (!rst && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got row %0d expected no output", out_row_o);
            end else begin
                e = sb.pop_front();
                chk("sb_row", out_row_o, e[NC+2:NC]);
                chk("sb_spike", out_spike_o, e[NC-1:0]);
            end
        end
        if (!rst && done_o) n_done++;
    end

    task automatic ts(input int sh, input bit lm, input bit rm, input int th, input int rf,
                      input int x, input logic [NC-1:0] sp, input bit stall = 0,
                      input bit hold = 0, input int abort = -1);
        logic [DW-1:0] xs;
        int n;
        xs = x[DW-1:0];
        shift_i = sh[1:0]; leak_mode_i = lm; reset_mode_i = rm;
        thresh_i = th[DW-1:0]; refr_i = rf[2:0];
        start_i = 1;
        @(posedge clk); #1;
        start_i = hold;
        shift_i = ~shift_i; leak_mode_i = ~lm; reset_mode_i = ~rm;
        thresh_i = ~thresh_i; refr_i = ~refr_i;
        chk("start_busy", busy_o, 1);
        chk("start_in_ready", in_ready_o, 1);
        for (int r = 0; r < NR; r++) begin
            if (stall) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            in_data_i = {NC{xs}};
            in_valid_i = 1;
            n = 0;
            while (!in_ready_o && n < 50) begin @(posedge clk); #1; n++; end
            if (n == 50) begin
                checks++; errors++;
                $display("FAIL in_timeout: got in_ready 0 expected 1 within 50 cycles");
            end
            @(posedge clk); #1;
            in_valid_i = 0;
            in_data_i = '0;
            if (r == abort) return;
            sb.push_back({r[2:0], sp});
            chk("row_out_valid", out_valid_o, 1);
            chk("row_in_ready_low", in_ready_o, 0);
            if (r == NR - 1) start_i = 0;
            if (stall) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            out_ready_i = 1;
            n = 0;
            while (!out_valid_o && n < 50) begin @(posedge clk); #1; n++; end
            if (n == 50) begin
                checks++; errors++;
                $display("FAIL out_timeout: got out_valid 0 expected 1 within 50 cycles");
            end
            @(posedge clk); #1;
            out_ready_i = 0;
            if (r < NR - 1) chk("turnaround_in_ready", in_ready_o, 1);
        end
        chk("done_pulse", done_o, 1);
        chk("done_busy", busy_o, 1);
        @(posedge clk); #1;
        chk("done_end", done_o, 0);
        chk("done_idle", busy_o, 0);
    endtask

    task automatic clr();
        clear_i = 1;
        @(posedge clk); #1;
        clear_i = 0;
        chk_mem("clear", 0);
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("rst");
        chk_mem("rst_mem", 0);
        rst = 0;
        @(posedge clk); #1;
        chk_idle_outputs("post_rst");

        ts(0, 0, 0, 100, 0, 50, '0); chk_mem("basic_v50", 50);
        ts(0, 0, 0, 100, 0, 50, '1); chk_mem("basic_v0", 0);

        clr(); ts(0, 0, 0, 32767, 0, 64, '0); chk_mem("pre64", 64);
        ts(2, 0, 0, 32767, 0, 0, '0); chk_mem("leak_m0", 16);
        clr(); ts(0, 0, 0, 32767, 0, 64, '0);
        ts(2, 1, 0, 32767, 0, 0, '0); chk_mem("leak_m1", 48);
        clr(); ts(0, 0, 0, 32767, 0, -64, '0); chk_mem("pre_neg64", -64);
        ts(2, 0, 0, 32767, 0, 0, '0); chk_mem("leak_neg", -16);
        ts(0, 1, 0, 32767, 0, 0, '0); chk_mem("leak_s0_m1", 0);

        clr(); ts(0, 0, 0, 32767, 0, 30000, '0); chk_mem("pre30000", 30000);
        ts(0, 0, 1, 30000, 0, 10000, '1); chk_mem("sat_soft", 2767);
        clr(); ts(0, 0, 0, 32767, 0, -32768, '0);
        ts(0, 0, 0, 32767, 0, -32768, '0); chk_mem("sat_neg", -32768);

        clr();
        ts(0, 0, 0, 10, 2, 20, '1); chk_mem("refr_t1", 0);
        ts(0, 0, 0, 10, 2, 20, '0); chk_mem("refr_t2", 0);
        ts(0, 0, 0, 10, 2, 20, '0); chk_mem("refr_t3", 0);
        ts(0, 0, 0, 10, 2, 20, '1); chk_mem("refr_t4", 0);
        clr();
        ts(0, 0, 1, 10, 1, 20, '1); chk_mem("refr_soft_t1", 10);
        ts(0, 0, 1, 10, 1, 20, '0); chk_mem("refr_soft_hold", 10);
        ts(0, 0, 1, 10, 1, 20, '1); chk_mem("refr_soft_t3", 20);

        clr();
        d0 = n_done;
        ts(0, 0, 0, 100, 0, 50, '0, 1, 1);
        chk("stall_done_count", n_done - d0, 1);
        chk_mem("stall_v", 50);

        start_i = 1; clear_i = 1;
        @(posedge clk); #1;
        start_i = 0; clear_i = 0;
        chk("start_clear_busy", busy_o, 0);
        chk("start_clear_in_ready", in_ready_o, 0);
        chk_mem("start_clear_mem", 0);

        ts(0, 0, 0, 100, 0, 7, '0); chk_mem("pre7", 7);
        ts(0, 0, 0, 100, 0, 7, '0, 0, 0, 3);
        chk("abort_out_valid", out_valid_o, 1);
        rst = 1;
        #1;
        chk_idle_outputs("rst_mid");
        chk_mem("rst_mid_mem", 0);
        chk("rst_mid_sb", sb.size(), 0);
        @(posedge clk); #1;
        rst = 0;
        ts(0, 0, 0, 5, 0, 5, '1); chk_mem("post_rst_v", 0);

        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog");
    end
endmodule
